// File: rtl/bcd_7seg_scan.sv
// Multi-digit BCD to seven-segment scanner: latches a digit vector, then time-multiplexes
// one digit per slot onto a shared segment bus with a blank slot at each digit change.
module bcd_7seg_scan #(
  parameter int unsigned  DIGITS     = 4,
  parameter int unsigned  SCAN_DIV   = 1024,
  parameter bit           ACTIVE_LOW = 1'b0,
  localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [IdxW-1:0]       idx
);

  localparam int unsigned     PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PLast   = PW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [PW-1:0]          p_q, p_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0][3:0] disp_q;
  logic [DIGITS-1:0]      mask_q, mask_d;
  logic [6:0]             seg_d;
  logic [DIGITS-1:0]      an_d;
  logic                   zero_run;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1100111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    p_d   = (p_q == PLast) ? '0 : p_q + 1'b1;
    idx_d = idx_q;
    if (p_q == PLast) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is blanked while it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    mask_d   = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run  = zero_run & (bcd[4*k +: 4] == 4'd0);
      mask_d[k] = zero_run & blank_lz;
    end
  end

  // p=0 is the anti-ghosting slot: everything off while the digit enable moves.
  always_comb begin
    seg_d = '0;
    an_d  = '0;
    if (p_q != '0) begin
      an_d[idx_q] = 1'b1;
      if (!mask_q[idx_q]) begin
        seg_d = decode(disp_q[idx_q]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      mask_q <= '0;
      seg    <= {7{ACTIVE_LOW}};
      an     <= {DIGITS{ACTIVE_LOW}};
      idx    <= '0;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
      if (load) begin
        disp_q <= bcd;
        mask_q <= mask_d;
      end
      seg <= seg_d ^ {7{ACTIVE_LOW}};
      an  <= an_d ^ {DIGITS{ACTIVE_LOW}};
      idx <= idx_q;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Randomized self-checking bench for bcd_7seg_scan: a 4-digit/4-cycle instance and a
// 1-digit/2-cycle active-low instance are both compared every cycle against a cycle-count model.
module tb_bcd_7seg_scan;

  localparam int unsigned D  = 4;
  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  bcd2 = '0;
  logic [6:0]  seg, seg2;
  logic [3:0]  an;
  logic [1:0]  idx;
  logic [0:0]  an2, idx2;

  always #5 clk = ~clk;

  bcd_7seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank_lz(blank_lz),
    .seg(seg), .an(an), .idx(idx)
  );

  bcd_7seg_scan #(.DIGITS(1), .SCAN_DIV(2), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .bcd(bcd2), .load(load), .blank_lz(blank_lz),
    .seg(seg2), .an(an2), .idx(idx2)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  logic [15:0] m_disp = '0;
  logic        m_lz = 1'b0;
  logic [3:0]  m_disp2 = '0;

  function automatic logic [6:0] seg_of(input int unsigned c);
    case (c)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  // Called at a negedge with inputs already driven; the output after edge n shows
  // p = n mod SD, idx = (n / SD) mod D and the display contents loaded before edge n.
  task automatic tick();
    int unsigned p, ix, dig;
    logic        masked;
    logic [6:0]  e_seg, e_seg2;
    logic [3:0]  e_an;
    logic [0:0]  e_an2;
    p      = cyc % SD;
    ix     = (cyc / SD) % D;
    dig    = (m_disp >> (4 * ix)) & 16'hF;
    masked = m_lz && (ix != 0) && ((m_disp >> (4 * ix)) == 16'd0);
    e_an   = (p == 0) ? 4'b0000 : 4'(1 << ix);
    e_seg  = (p == 0 || masked) ? 7'b0 : seg_of(dig);
    e_seg2 = ((cyc % 2) == 0) ? 7'h7F : ~seg_of(m_disp2);
    e_an2  = ((cyc % 2) == 0) ? 1'b1 : 1'b0;
    if (load) begin
      m_disp  = bcd;
      m_lz    = blank_lz;
      m_disp2 = bcd2;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("idx", 32'(idx), 32'(ix));
    check("seg_al", 32'(seg2), 32'(e_seg2));
    check("an_al", 32'(an2), 32'(e_an2));
    check("idx_al", 32'(idx2), 32'd0);
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks the outputs before any edge can occur.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_an", 32'(an), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_seg_al", 32'(seg2), 32'h7F);
    check("rst_an_al", 32'(an2), 32'd1);
    m_disp  = '0;
    m_lz    = 1'b0;
    m_disp2 = '0;
    cyc     = 0;
    load    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_val(input logic [15:0] v, input logic lz, input logic [3:0] v2);
    bcd      = v;
    blank_lz = lz;
    bcd2     = v2;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    bcd      = 16'($urandom);
    bcd2     = 4'($urandom);
    blank_lz = 1'($urandom);
    repeat (2 * D * SD) tick();
  endtask

  initial begin
    do_reset();
    repeat (6) tick();
    load_val(16'h9876, 1'b0, 4'd8);
    load_val(16'h5432, 1'b0, 4'd3);
    load_val(16'h1010, 1'b0, 4'd0);
    load_val(16'h0050, 1'b1, 4'd8);
    load_val(16'h0000, 1'b1, 4'd0);
    load_val(16'h0050, 1'b0, 4'd7);
    load_val(16'hFA3C, 1'b0, 4'hB);

    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      bcd2     = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom);
      tick();
    end
    load = 1'b0;

    repeat (5) tick();
    do_reset();
    repeat (10) tick();
    load_val(16'h1111, 1'b0, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (vectors %0d)", n_vec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Parametrised multi-digit BCD to seven-segment display driver with time-multiplexed digit scanning. It latches a packed vector of BCD digits and decodes one digit at a time onto a shared segment bus. It drives a one-hot digit-enable bus, inserts an anti-ghosting blank slot at every digit change, and optionally blanks leading zeros. It sits between the numeric datapath (counters, timers) and the board's common-segment display pins.

## Interface
- DIGITS, 4: number of display digits; legal range 1..8.
- SCAN_DIV, 1024: clock cycles per digit slot; legal range 2..65535.
- ACTIVE_LOW, 0: output polarity.
  - 1 inverts both `seg` and `an` at the pins.
  - All values in this document are logical, with 1 = lit/enabled.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bcd  input  4*DIGITS  packed digits; digit k is bcd[4k+3:4k]; digit 0 is least significant.
- load  input  1  when 1 at a rising edge, bcd and blank_lz are captured into the display register.
- blank_lz  input  1  leading-zero blanking enable; captured with load.
- seg  output  7  segment drive; seg[0]=a … seg[6]=g.
- an  output  DIGITS  one-hot digit enable; all-inactive during the blank slot.
- idx  output  clog2(DIGITS), minimum 1  index of the digit currently scanned.

## Operation
- **Decode map.** The logical seg value for each BCD code is:
  - 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110
  - 5→1101101, 6→1111101, 7→0000111, 8→1111111, 9→1100111
  - codes 10–15 → 0000000 (blank); the enable for that digit is still driven.
- **Display register.** Holds DIGITS×4 bits plus a DIGITS-bit blank mask.
  - It changes only on a load edge; the bcd input is ignored otherwise.
- **Blank mask.** Computed at load time from the incoming bcd when blank_lz=1.
  - Digit k is masked if it and every digit above it equal 0.
  - Digit 0 is never masked, so all-zero input displays "0".
  - With blank_lz=0 the mask is all zero.
  - A masked digit drives seg=0000000 and keeps its `an` bit active.
- **Prescaler.** p counts 0..SCAN_DIV-1 and wraps to 0.
  - When p wraps, idx advances by 1, with DIGITS-1 wrapping to 0.
  - If DIGITS=1, idx stays 0.
- **Slot structure**, per digit and SCAN_DIV cycles long:
  - p=0: blank slot; an=0, seg=0.
  - p=1..SCAN_DIV-1: an has only bit idx set; seg is the decoded (or masked) pattern of digit idx.
- **Scan order** is 0,1,…,DIGITS-1,0,… Scanning is free-running and does not depend on load.
- **Reset** (rst_n=0, asynchronous assertion):
  - p=0, idx=0, display register=0, mask=0.
  - seg and an are forced to their inactive pin level: 0 if ACTIVE_LOW=0, all-ones if ACTIVE_LOW=1.
- **Reset release.** Scanning starts from idx=0, p=0, so the first cycle is a blank slot.
- **Reset mid-scan.** Returns immediately to the reset state; no partial slot completes.

## Timing
- seg, an and idx are registered outputs. They reflect p, idx and the display register as they stood after the previous edge.
- No combinational path exists from any input to any output.
- **Load latency.** After a load at edge t, the new digit values appear on seg from edge t+1, if the active slot is non-blank.
  - A load during the blank slot is shown when that slot's active phase begins.
- **Back-to-back loads.** Each load overwrites the register; the last one wins. No loads are queued.
- **Full frame** = DIGITS×SCAN_DIV cycles.
- **Duty per digit** = (SCAN_DIV-1)/(DIGITS×SCAN_DIV).
- **idx timing.** idx changes on the same edge that p wraps to 0.
  - The blank slot and the new idx therefore appear together.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4 unless stated.

1. **Reset values.** Assert rst_n=0 mid-slot → on the same cycle, without waiting for an edge, seg=0, an=0000, idx=0. After release → the first 4 cycles show slot 0: cycle 0 all off, cycles 1–3 with an=0001.
2. **Full decode sweep.** Load 0x9876, then 0x5432, then 0x1010 → over each 16-cycle frame, every seg value matches the decode table. Also verify each an one-hot position against idx.
3. **Leading-zero blanking.** Load bcd=0x0050 with blank_lz=1 → digits 3 and 2 show seg=0000000 while their an bit is active; digit 1 shows 1101101; digit 0 shows 0111111.
   - Load 0x0000 with blank_lz=1 → only digit 0 shows 0111111.
   - Load 0x0050 with blank_lz=0 → all four digits are lit.
4. **Invalid codes.** Load 0xFA3C → digits 0 (C), 2 (A) and 3 (F) show seg=0; digit 1 shows 1001111.
5. **Load timing.** Load 0x1111 at an edge in the middle of a digit-2 active cycle → the next cycle shows 0000110 with an=0100. A load held for a single cycle persists indefinitely afterwards.
6. **Polarity and size.** With ACTIVE_LOW=1, DIGITS=1, SCAN_DIV=2 → during reset seg=1111111 and an=1. Loading 8 gives pins alternating each cycle between seg=1111111/an=1 and seg=0000000/an=0. idx stays 0.
